// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
//
// Time-multiplexes NUM_DIGITS BCD digits onto one shared seven-segment bus.
// Each digit gets a BLANK-cycle all-off gap (ghost suppression) followed by a
// DWELL-cycle drive window whose lit portion is set by a 4-bit brightness.
// Digit values are double-buffered (staging -> shadow) and the shadow is only
// replaced at a frame boundary, so an update never tears mid-frame.
//
// Parameters:
//   NUM_DIGITS  digits scanned per frame (1..8)
//   DWELL       drive cycles per digit (multiple of 16, >= 16)
//   BLANK       all-off cycles between digits (1..255)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   ena         scan enable; low forces idle with all outputs off
//   digit_data  BCD digits, digit i at [4i+3:4i]
//   load        one-cycle strobe capturing digit_data
//   brightness  duty level 0..15, sampled on each drive entry
//   segments    registered segment drive, bit0=a .. bit6=g, active-high
//   digit_sel   registered one-hot digit enable, active-high
//   frame_done  registered one-cycle pulse at each frame boundary
//   busy        high whenever the scanner is not idle

module seg_scan_scheduler #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 1024,
  parameter int unsigned BLANK      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [4*NUM_DIGITS-1:0]   digit_data,
  input  logic                      load,
  input  logic [3:0]                brightness,
  output logic [6:0]                segments,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
  // Counter only needs to reach CntMax-1.
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // One brightness step is DWELL/16 lit cycles.
  localparam int unsigned Step   = DWELL / 16;
  localparam int unsigned DataW  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [3:0]             bri_q, bri_d;
  logic [DataW-1:0]       staging_q, staging_d;
  logic [DataW-1:0]       shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [6:0]             segments_q, segments_d;
  logic [NUM_DIGITS-1:0]  digit_sel_q, digit_sel_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;

  logic                   boundary;
  logic [3:0]             digit_val;
  logic [31:0]            on_len;
  logic                   lit;

  // Standard common-cathode decode; non-BCD codes blank the digit.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Sequencing: idle -> blank -> drive -> blank -> ... with idx advancing per digit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    bri_d    = bri_q;
    boundary = 1'b0;

    if (!ena) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == CntW'(BLANK - 1)) begin
            state_d = StDrive;
            cnt_d   = '0;
            // Brightness is frozen for the whole drive window.
            bri_d   = brightness;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (cnt_q == CntW'(DWELL - 1)) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer. A load is applied straight to the shadow when nothing is
  // being displayed from it mid-frame: while idle, or during the frame_done
  // cycle (the new frame's first drive is still BLANK cycles away).
  always_comb begin
    staging_d    = staging_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = boundary;

    if (boundary && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end

    if (load) begin
      if (state_q == StIdle || frame_done_q) begin
        // Direct write supersedes any older staged value.
        shadow_d  = digit_data;
        pending_d = 1'b0;
      end else begin
        staging_d = digit_data;
        pending_d = 1'b1;
      end
    end
  end

  // Registered outputs are computed from next-state values so they change on
  // the same edge as the state they describe.
  always_comb begin
    digit_val = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        digit_val = shadow_d[4*i +: 4];
      end
    end

    on_len = (32'(bri_d) + 32'd1) * Step;
    lit    = (state_d == StDrive) && (32'(cnt_d) < on_len);

    segments_d = lit ? decode(digit_val) : 7'h00;

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digit_sel_d[i] = (state_d == StDrive) && (idx_d == IdxW'(i));
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      bri_q        <= '0;
      staging_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      segments_q   <= '0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bri_q        <= bri_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      segments_q   <= segments_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign segments   = segments_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with NUM_DIGITS=4, DWELL=32, BLANK=2.
// scan_digit observes one digit period starting at its first drive cycle;
// each test task compares those observations against hand-computed values.

module tb_seg_scan_scheduler;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  brightness;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent scan_digit call.
  logic [3:0] obs_sel;
  logic [6:0] obs_seg;
  logic [7:0] obs_on;
  logic       obs_fd;
  int         obs_bad;

  seg_scan_scheduler #(
    .NUM_DIGITS(ND),
    .DWELL     (DW),
    .BLANK     (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .digit_data(digit_data),
    .load      (load),
    .brightness(brightness),
    .segments  (segments),
    .digit_sel (digit_sel),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the first drive cycle of a digit; returns at the next digit's
  // first drive cycle. Optional load / brightness change at drive cycle *_at.
  task automatic scan_digit(input int load_at, input logic [15:0] load_val,
                            input int bri_at, input logic [3:0] bri_val);
    int bad;
    bit seen_off;
    bad      = 0;
    seen_off = 1'b0;
    obs_sel  = digit_sel;
    obs_seg  = segments;
    obs_on   = 8'd0;
    for (int i = 0; i < int'(DW); i++) begin
      if (digit_sel !== obs_sel) bad++;
      if (frame_done !== 1'b0) bad++;
      if (segments !== 7'd0) begin
        obs_on++;
        if (seen_off || segments !== obs_seg) bad++;
      end else begin
        seen_off = 1'b1;
      end
      if (i == load_at) begin
        digit_data = load_val;
        load       = 1'b1;
      end
      if (i == bri_at) brightness = bri_val;
      tick();
      load = 1'b0;
    end
    obs_fd = frame_done;
    for (int i = 0; i < int'(BL); i++) begin
      if (digit_sel !== 4'd0 || segments !== 7'd0) bad++;
      if (i > 0 && frame_done !== 1'b0) bad++;
      tick();
    end
    obs_bad = bad;
  endtask

  task automatic wait_sel(output int n);
    n = 0;
    while (digit_sel === 4'd0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic to_frame_done(output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ena        = 1'b0;
    load       = 1'b0;
    digit_data = 16'h0000;
    brightness = 4'd15;
    tick();
    tick();
    checks++;
    if ({segments, digit_sel, frame_done, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got seg=%h sel=%b fd=%b busy=%b, want all 0",
               segments, digit_sel, frame_done, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({segments, digit_sel, frame_done, busy} !== 13'd0) begin
      failures++;
      $display("FAIL idle_outputs: got seg=%h sel=%b fd=%b busy=%b, want all 0",
               segments, digit_sel, frame_done, busy);
    end
    digit_data = 16'h4321;
    load       = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if ({digit_sel, busy} !== 5'd0) begin
      failures++;
      $display("FAIL idle_load: got sel=%b busy=%b, want 0 0", digit_sel, busy);
    end
  endtask

  task automatic test_start();
    int n;
    logic [27:0] segs;
    segs = {7'h66, 7'h4F, 7'h5B, 7'h06};
    ena = 1'b1;
    wait_sel(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL start_latency: got %0d cycles, want 3", n);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy: got %b, want 1", busy);
    end
    for (int d = 0; d < 4; d++) begin
      scan_digit(-1, 16'h0, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], 8'd32, d == 3}) begin
        failures++;
        $display("FAIL start_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=32 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], d == 3);
      end
      checks++;
      if (obs_bad !== 0) begin
        failures++;
        $display("FAIL start_stable_d%0d: got %0d bad cycles, want 0", d, obs_bad);
      end
    end
  endtask

  task automatic test_brightness();
    int n;
    logic [27:0] segs;
    logic [31:0] ons;
    segs = {7'h66, 7'h4F, 7'h5B, 7'h06};
    // From digit 0's first drive cycle to the pulse is 134; the previous
    // pulse was 2 cycles before that cycle, giving a 136-cycle period.
    to_frame_done(n);
    checks++;
    if (n !== 134) begin
      failures++;
      $display("FAIL frame_period: got %0d, want 134 (+2)", n);
    end
    brightness = 4'd3;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      scan_digit(-1, 16'h0, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], 8'd8, d == 3}) begin
        failures++;
        $display("FAIL bri3_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=8 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], d == 3);
      end
      checks++;
      if (obs_bad !== 0) begin
        failures++;
        $display("FAIL bri3_stable_d%0d: got %0d bad cycles, want 0", d, obs_bad);
      end
    end
    // Raise brightness mid-drive of digit 0: takes effect from digit 1.
    ons = {8'd32, 8'd32, 8'd32, 8'd8};
    for (int d = 0; d < 4; d++) begin
      scan_digit(-1, 16'h0, (d == 0) ? 4 : -1, 4'd15);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], ons[8*d +: 8], d == 3}) begin
        failures++;
        $display("FAIL bri_change_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=%0d fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], ons[8*d +: 8], d == 3);
      end
      checks++;
      if (obs_bad !== 0) begin
        failures++;
        $display("FAIL bri_change_stable_d%0d: got %0d bad cycles, want 0", d, obs_bad);
      end
    end
  endtask

  task automatic test_tear();
    logic [27:0] segs;
    logic [15:0] lval;
    // Frame: load 9999 during digit 1, current frame keeps 4321.
    segs = {7'h66, 7'h4F, 7'h5B, 7'h06};
    for (int d = 0; d < 4; d++) begin
      scan_digit((d == 1) ? 5 : -1, 16'h9999, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], 8'd32, d == 3}) begin
        failures++;
        $display("FAIL tear_old_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=32 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], d == 3);
      end
    end
    // Frame shows 9999; two loads here, only 8765 should survive.
    segs = {7'h6F, 7'h6F, 7'h6F, 7'h6F};
    for (int d = 0; d < 4; d++) begin
      lval = (d == 1) ? 16'h5678 : 16'h8765;
      scan_digit((d == 1 || d == 2) ? 5 : -1, lval, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], 8'd32, d == 3}) begin
        failures++;
        $display("FAIL tear_new_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=32 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], d == 3);
      end
      checks++;
      if (obs_bad !== 0) begin
        failures++;
        $display("FAIL tear_new_stable_d%0d: got %0d bad cycles, want 0", d, obs_bad);
      end
    end
    segs = {7'h7F, 7'h07, 7'h7D, 7'h6D};
    for (int d = 0; d < 4; d++) begin
      scan_digit(-1, 16'h0, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], 8'd32, d == 3}) begin
        failures++;
        $display("FAIL last_load_wins_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=32 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], d == 3);
      end
    end
  endtask

  task automatic test_boundary_load();
    int n;
    logic [27:0] segs;
    logic [6:0]  sexp;
    // Staged 2222 is swapped in at the boundary, then overwritten by the
    // load made on the frame_done cycle itself.
    digit_data = 16'h2222;
    load       = 1'b1;
    tick();
    load = 1'b0;
    to_frame_done(n);
    checks++;
    if (n !== 133) begin
      failures++;
      $display("FAIL boundary_sync: got %0d, want 133", n);
    end
    digit_data = 16'hFA00;
    load       = 1'b1;
    tick();
    load = 1'b0;
    tick();
    segs = {7'h00, 7'h00, 7'h3F, 7'h3F};
    for (int d = 0; d < 4; d++) begin
      scan_digit((d == 0) ? 3 : -1, 16'hEDCB, -1, 4'd0);
      sexp = segs[7*d +: 7];
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), sexp, (sexp != 7'h00) ? 8'd32 : 8'd0, d == 3}) begin
        failures++;
        $display("FAIL boundary_load_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), sexp, d == 3);
      end
      checks++;
      if (obs_bad !== 0) begin
        failures++;
        $display("FAIL boundary_load_stable_d%0d: got %0d bad cycles, want 0", d, obs_bad);
      end
    end
    // Codes B..E: blank segments, select still walks one-hot.
    for (int d = 0; d < 4; d++) begin
      scan_digit((d == 0) ? 3 : -1, 16'h4321, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), 7'h00, 8'd0, d == 3}) begin
        failures++;
        $display("FAIL non_bcd_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=00 on=0 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), d == 3);
      end
    end
  endtask

  task automatic test_enable();
    int n;
    logic [27:0] segs;
    segs = {7'h66, 7'h4F, 7'h5B, 7'h06};
    for (int d = 0; d < 2; d++) begin
      scan_digit(-1, 16'h0, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg} !== {4'(1 << d), segs[7*d +: 7]}) begin
        failures++;
        $display("FAIL pre_drop_d%0d: got sel=%b seg=%h, want sel=%b seg=%h",
                 d, obs_sel, obs_seg, 4'(1 << d), segs[7*d +: 7]);
      end
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({digit_sel, segments} !== {4'b0100, 7'h4F}) begin
      failures++;
      $display("FAIL drive_d2: got sel=%b seg=%h, want 0100 4f", digit_sel, segments);
    end
    ena = 1'b0;
    tick();
    checks++;
    if ({segments, digit_sel, frame_done, busy} !== 13'd0) begin
      failures++;
      $display("FAIL ena_drop: got seg=%h sel=%b fd=%b busy=%b, want all 0",
               segments, digit_sel, frame_done, busy);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({segments, digit_sel, frame_done, busy} !== 13'd0) begin
      failures++;
      $display("FAIL ena_idle: got seg=%h sel=%b fd=%b busy=%b, want all 0",
               segments, digit_sel, frame_done, busy);
    end
    ena = 1'b1;
    wait_sel(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL restart_latency: got %0d cycles, want 3", n);
    end
    for (int d = 0; d < 4; d++) begin
      scan_digit(-1, 16'h0, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << d), segs[7*d +: 7], 8'd32, d == 3}) begin
        failures++;
        $display("FAIL restart_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=%h on=32 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << d), segs[7*d +: 7], d == 3);
      end
    end
  endtask

  task automatic test_reset_interrupt();
    int n;
    digit_data = 16'h9999;
    load       = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    // Reset wins over a simultaneous load and a high enable.
    rst        = 1'b1;
    load       = 1'b1;
    digit_data = 16'h5555;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    checks++;
    if ({segments, digit_sel, frame_done, busy} !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset: got seg=%h sel=%b fd=%b busy=%b, want all 0",
               segments, digit_sel, frame_done, busy);
    end
    wait_sel(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL reset_restart_latency: got %0d cycles, want 3", n);
    end
    for (int d = 0; d < 5; d++) begin
      scan_digit(-1, 16'h0, -1, 4'd0);
      checks++;
      if ({obs_sel, obs_seg, obs_on, obs_fd} !== {4'(1 << (d % 4)), 7'h3F, 8'd32, d == 3}) begin
        failures++;
        $display("FAIL reset_cleared_d%0d: got sel=%b seg=%h on=%0d fd=%b, want sel=%b seg=3f on=32 fd=%b",
                 d, obs_sel, obs_seg, obs_on, obs_fd, 4'(1 << (d % 4)), d == 3);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    ena        = 1'b0;
    load       = 1'b0;
    digit_data = 16'h0000;
    brightness = 4'd15;
    test_reset();
    test_start();
    test_brightness();
    test_tear();
    test_boundary_load();
    test_enable();
    test_reset_interrupt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
